// File: rtl/ucode_sequencer.sv
// ucode_sequencer: fetches opcode bytes, folds the 0xCB prefix into a 9-bit microcode
// index, steps through micro-ops, injects interrupt entry at instruction boundaries
// and parks the core in HALT.
// Optional feature: define UCODE_SEQ_ILLEGAL_TRAP_EN to lock up on illegal opcodes.
module ucode_sequencer #(
  parameter logic [8:0] IRQ_OPCODE = 9'h0FD,
  parameter logic [2:0] MAX_STEP   = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       fetch_req,
  input  logic       mem_valid,
  input  logic [7:0] instr_byte,
  output logic [8:0] uop_addr,
  output logic [2:0] uop_step,
  output logic       uop_valid,
  input  logic       uop_stall,
  input  logic       uop_last,
  input  logic       uop_halt,
  input  logic       irq_pending,
  input  logic       ime,
  output logic       irq_ack,
  output logic       illegal_op
);

  typedef enum logic [2:0] {
    StFetch,
    StCbFetch,
    StExec,
    StIrq,
    StHalt
`ifdef UCODE_SEQ_ILLEGAL_TRAP_EN
    , StLock
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] addr_q, addr_d;
  logic [2:0] step_q, step_d;
  logic       fetch_req_q, fetch_req_d;
  logic       valid_q, valid_d;
  logic       ack_q;
  logic       dispatch;
  logic       transfer;
  logic       step_end;

  // The handshake only counts while fetch_req is actually being driven.
  assign transfer = fetch_req_q && mem_valid;
  // A step counter at MAX_STEP ends the instruction even without uop_last.
  assign step_end = uop_last || (step_q == MAX_STEP);

`ifdef UCODE_SEQ_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  logic byte_illegal;

  // Unused LR35902 opcode slots; only meaningful for unprefixed bytes.
  always_comb begin
    byte_illegal = 1'b0;
    case (instr_byte)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: byte_illegal = 1'b1;
      default:                           byte_illegal = 1'b0;
    endcase
  end
`endif

  // Next-state, next-index and next-step selection.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    step_d   = step_q;
    dispatch = 1'b0;
`ifdef UCODE_SEQ_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      StFetch: begin
        if (transfer) begin
          if (instr_byte == 8'hCB) begin
            state_d = StCbFetch;
`ifdef UCODE_SEQ_ILLEGAL_TRAP_EN
          end else if (byte_illegal) begin
            state_d   = StLock;
            illegal_d = 1'b1;
`endif
          end else begin
            state_d = StExec;
            addr_d  = {1'b0, instr_byte};
            step_d  = 3'd0;
          end
        end
      end
      StCbFetch: begin
        if (transfer) begin
          state_d = StExec;
          addr_d  = {1'b1, instr_byte};
          step_d  = 3'd0;
        end
      end
      StExec, StIrq: begin
        // Stall outranks the end condition; IRQ behaves exactly like EXEC after entry.
        if (!uop_stall) begin
          if (step_end) begin
            if (uop_halt) begin
              state_d = StHalt;
            end else if (irq_pending && ime) begin
              dispatch = 1'b1;
            end else begin
              state_d = StFetch;
            end
          end else begin
            state_d = StExec;
            step_d  = step_q + 3'd1;
          end
        end
      end
      StHalt: begin
        if (irq_pending) begin
          if (ime) begin
            dispatch = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
`ifdef UCODE_SEQ_ILLEGAL_TRAP_EN
      StLock: state_d = StLock;
`endif
      default: state_d = StFetch;
    endcase
    if (dispatch) begin
      state_d = StIrq;
      addr_d  = IRQ_OPCODE;
      step_d  = 3'd0;
    end
  end

  // Outputs are registered, so derive them from the state being entered.
  always_comb begin
    fetch_req_d = (state_d == StFetch) || (state_d == StCbFetch);
    valid_d     = (state_d == StExec) || (state_d == StIrq);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      addr_q      <= 9'd0;
      step_q      <= 3'd0;
      fetch_req_q <= 1'b0;
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      step_q      <= step_d;
      fetch_req_q <= fetch_req_d;
      valid_q     <= valid_d;
      ack_q       <= dispatch;
    end
  end

`ifdef UCODE_SEQ_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign fetch_req = fetch_req_q;
  assign uop_valid = valid_q;
  assign uop_addr  = addr_q;
  assign uop_step  = step_q;
  assign irq_ack   = ack_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: expected {irq_ack, uop_addr, uop_step}
// triples are queued as stimulus is driven and compared on every uop_valid cycle.
module tb_ucode_sequencer;

  logic       clk;
  logic       rst_n;
  logic       fetch_req;
  logic       mem_valid;
  logic [7:0] instr_byte;
  logic [8:0] uop_addr;
  logic [2:0] uop_step;
  logic       uop_valid;
  logic       uop_stall;
  logic       uop_last;
  logic       uop_halt;
  logic       irq_pending;
  logic       ime;
  logic       irq_ack;
  logic       illegal_op;

  int errors = 0;
  int checks = 0;

  // Scoreboard of expected {ack, addr, step}.
  logic [12:0] sb[$];

  // Byte memory feeding the fetch path; rd_ptr advances on each transfer.
  logic [7:0] mem[256];
  int mem_len = 0;
  int rd_ptr  = 0;

  // Control-word model: fixed last step, or last step taken from the index LSBs.
  int   last_step = 0;
  logic len_mode  = 1'b0;

  ucode_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .mem_valid  (mem_valid),
    .instr_byte (instr_byte),
    .uop_addr   (uop_addr),
    .uop_step   (uop_step),
    .uop_valid  (uop_valid),
    .uop_stall  (uop_stall),
    .uop_last   (uop_last),
    .uop_halt   (uop_halt),
    .irq_pending(irq_pending),
    .ime        (ime),
    .irq_ack    (irq_ack),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_valid  = (rd_ptr < mem_len);
  assign instr_byte = mem[rd_ptr[7:0]];
  assign uop_last   = len_mode ? (uop_step == {1'b0, uop_addr[1:0]})
                               : (int'(uop_step) == last_step);

  always @(posedge clk) begin
    if (fetch_req && mem_valid) rd_ptr <= rd_ptr + 1;
  end

  function automatic bit is_illegal_byte(input logic [7:0] b);
    case (b)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  task automatic append(input logic [7:0] b);
    mem[mem_len[7:0]] = b;
    mem_len = mem_len + 1;
  endtask

  task automatic push_op(input logic [8:0] addr, input int nsteps);
    for (int s = 0; s < nsteps; s++) sb.push_back({1'b0, addr, 3'(s)});
  endtask

  // One clock cycle: scoreboard compare mid-cycle, return just after the next edge.
  task automatic tick();
    logic [12:0] exp;
    @(negedge clk);
    if (rst_n && uop_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_extra: got ack=%0b addr=%03h step=%0d, expected nothing",
                 irq_ack, uop_addr, uop_step);
      end else begin
        exp = sb.pop_front();
        if ({irq_ack, uop_addr, uop_step} !== exp) begin
          errors++;
          $display("FAIL scoreboard_uop: got ack=%0b addr=%03h step=%0d, expected ack=%0b addr=%03h step=%0d",
                   irq_ack, uop_addr, uop_step, exp[12], exp[11:3], exp[2:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; uop_stall = 1'b0; uop_halt = 1'b0; irq_pending = 1'b0; ime = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_fetch_req: got %0b expected 0", fetch_req); end
    checks++; if (uop_valid !== 1'b0) begin errors++; $display("FAIL reset_uop_valid: got %0b expected 0", uop_valid); end
    checks++; if (uop_addr !== 9'h000) begin errors++; $display("FAIL reset_uop_addr: got %03h expected 000", uop_addr); end
    checks++; if (uop_step !== 3'd0) begin errors++; $display("FAIL reset_uop_step: got %0d expected 0", uop_step); end
    checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL reset_irq_ack: got %0b expected 0", irq_ack); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal_op: got %0b expected 0", illegal_op); end
    rst_n = 1'b1;
    tick();
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL reset_release_fetch: got %0b expected 1", fetch_req); end
  endtask

  task automatic test_nop_loop();
    int start = rd_ptr;
    last_step = 0;
    push_op(9'h000, 1); push_op(9'h000, 1); push_op(9'h000, 1);
    append(8'h00); append(8'h00); append(8'h00);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (uop_valid !== 1'((i % 2) == 1) || fetch_req !== 1'((i % 2) == 0)) begin
        errors++;
        $display("FAIL nop_loop_cycle%0d: got valid=%0b fetch=%0b expected valid=%0b fetch=%0b",
                 i, uop_valid, fetch_req, (i % 2) == 1, (i % 2) == 0);
      end
      tick();
    end
    repeat (2) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL nop_loop_drain: got %0d pending expected 0", sb.size()); end
    checks++; if (rd_ptr - start != 3) begin errors++; $display("FAIL nop_loop_transfers: got %0d expected 3", rd_ptr - start); end
  endtask

  task automatic test_cb_prefix();
    int start = rd_ptr;
    last_step = 1;
    push_op(9'h137, 2);
    append(8'hCB); append(8'h37);
    repeat (6) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL cb_drain: got %0d pending expected 0", sb.size()); end
    checks++; if (rd_ptr - start != 2) begin errors++; $display("FAIL cb_transfers: got %0d expected 2", rd_ptr - start); end
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL cb_back_to_fetch: got %0b expected 1", fetch_req); end
  endtask

  task automatic test_stall();
    last_step = 2;
    sb.push_back({1'b0, 9'h012, 3'd0});
    sb.push_back({1'b0, 9'h012, 3'd1});
    sb.push_back({1'b0, 9'h012, 3'd1});
    sb.push_back({1'b0, 9'h012, 3'd1});
    sb.push_back({1'b0, 9'h012, 3'd2});
    append(8'h12);
    tick(); tick();
    uop_stall = 1'b1;
    tick(); tick();
    uop_stall = 1'b0;
    repeat (4) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d pending expected 0", sb.size()); end
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL stall_back_to_fetch: got %0b expected 1", fetch_req); end
  endtask

  task automatic test_max_step();
    last_step = 9;
    push_op(9'h040, 8);
    append(8'h40);
    repeat (10) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL max_step_drain: got %0d pending expected 0", sb.size()); end
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL max_step_fetch: got %0b expected 1", fetch_req); end
  endtask

  task automatic test_irq();
    last_step = 2; ime = 1'b1;
    push_op(9'h034, 3);
    sb.push_back({1'b1, 9'h0FD, 3'd0});
    sb.push_back({1'b0, 9'h0FD, 3'd1});
    sb.push_back({1'b0, 9'h0FD, 3'd2});
    append(8'h34);
    tick(); tick();
    irq_pending = 1'b1;
    tick(); tick();
    checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL irq_ack_pulse: got %0b expected 1", irq_ack); end
    tick();
    ime = 1'b0;
    checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL irq_ack_width: got %0b expected 0", irq_ack); end
    tick(); tick();
    checks++; if (fetch_req !== 1'b1 || uop_valid !== 1'b0) begin
      errors++; $display("FAIL irq_nested_no_ime: got fetch=%0b valid=%0b expected 1 0", fetch_req, uop_valid);
    end
    last_step = 0;
    push_op(9'h005, 1);
    append(8'h05);
    tick(); tick();
    checks++; if (fetch_req !== 1'b1 || uop_valid !== 1'b0 || irq_ack !== 1'b0) begin
      errors++; $display("FAIL irq_ime0_fetch: got fetch=%0b valid=%0b ack=%0b expected 1 0 0",
                         fetch_req, uop_valid, irq_ack);
    end
    irq_pending = 1'b0;
    tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL irq_drain: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_halt();
    last_step = 0; uop_halt = 1'b1;
    push_op(9'h076, 1);
    append(8'h76);
    tick(); tick();
    uop_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (fetch_req !== 1'b0 || uop_valid !== 1'b0) begin
        errors++; $display("FAIL halt_idle%0d: got fetch=%0b valid=%0b expected 0 0", i, fetch_req, uop_valid);
      end
      tick();
    end
    irq_pending = 1'b1; ime = 1'b0;
    tick();
    checks++; if (fetch_req !== 1'b1 || uop_valid !== 1'b0 || irq_ack !== 1'b0) begin
      errors++; $display("FAIL halt_exit_no_ime: got fetch=%0b valid=%0b ack=%0b expected 1 0 0",
                         fetch_req, uop_valid, irq_ack);
    end
    irq_pending = 1'b0; uop_halt = 1'b1;
    push_op(9'h076, 1);
    append(8'h76);
    tick(); tick();
    uop_halt = 1'b0;
    checks++; if (fetch_req !== 1'b0 || uop_valid !== 1'b0) begin
      errors++; $display("FAIL halt_reentry: got fetch=%0b valid=%0b expected 0 0", fetch_req, uop_valid);
    end
    irq_pending = 1'b1; ime = 1'b1;
    sb.push_back({1'b1, 9'h0FD, 3'd0});
    tick();
    checks++; if (irq_ack !== 1'b1 || uop_valid !== 1'b1) begin
      errors++; $display("FAIL halt_exit_irq: got ack=%0b valid=%0b expected 1 1", irq_ack, uop_valid);
    end
    irq_pending = 1'b0;
    tick();
    ime = 1'b0;
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL halt_irq_return: got %0b expected 1", fetch_req); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL halt_drain: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic [8:0] a;
    len_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k % 3 == 0) begin
        b = 8'($urandom_range(0, 255));
        append(8'hCB); append(b);
        a = {1'b1, b};
      end else begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hCB || is_illegal_byte(b));
        append(b);
        a = {1'b0, b};
      end
      push_op(a, int'(a[1:0]) + 1);
    end
    for (int i = 0; i < 80 && sb.size() != 0; i++) tick();
    tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending expected 0", sb.size()); end
    checks++; if (rd_ptr != mem_len) begin errors++; $display("FAIL b2b_bytes: got rd=%0d expected %0d", rd_ptr, mem_len); end
    len_mode = 1'b0;
  endtask

  task automatic test_illegal();
`ifdef UCODE_SEQ_ILLEGAL_TRAP_EN
    append(8'hD3);
    tick();
    checks++; if (illegal_op !== 1'b1 || fetch_req !== 1'b0 || uop_valid !== 1'b0) begin
      errors++; $display("FAIL trap_lock: got illegal=%0b fetch=%0b valid=%0b expected 1 0 0",
                         illegal_op, fetch_req, uop_valid);
    end
    irq_pending = 1'b1; ime = 1'b1;
    repeat (3) tick();
    checks++; if (illegal_op !== 1'b1 || fetch_req !== 1'b0 || uop_valid !== 1'b0 || irq_ack !== 1'b0) begin
      errors++; $display("FAIL trap_ignores_irq: got illegal=%0b fetch=%0b valid=%0b ack=%0b expected 1 0 0 0",
                         illegal_op, fetch_req, uop_valid, irq_ack);
    end
    rst_n = 1'b0; irq_pending = 1'b0; ime = 1'b0;
    tick();
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL trap_reset_clear: got %0b expected 0", illegal_op); end
    rst_n = 1'b1;
    tick();
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL trap_reset_fetch: got %0b expected 1", fetch_req); end
`else
    last_step = 0;
    push_op(9'h0D3, 1);
    append(8'hD3);
    repeat (3) tick();
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_tied_low: got %0b expected 0", illegal_op); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL illegal_exec_drain: got %0d pending expected 0", sb.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_nop_loop();
    test_cb_prefix();
    test_stall();
    test_max_step();
    test_irq();
    test_halt();
    test_back_to_back();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ucode_sequencer.md
# ucode_sequencer

Sequences the CPU microcode ROM. It fetches opcode bytes over a valid handshake and folds the 0xCB prefix into a 9-bit microcode index. It steps through the micro-ops of each instruction and injects the interrupt-entry pseudo-opcode at instruction boundaries. It also parks the core in HALT. It sits between the memory-bus fetch path and the microcode lookup, and drives the lookup's 9-bit opcode input.

## Interface
- IRQ_OPCODE, 9'h0FD: microcode index executed for interrupt entry (unused LR35902 opcode slot).
- MAX_STEP, 7: last legal micro-step index; a step counter at MAX_STEP is treated as an implicit last step.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- fetch_req  out  1  request the next instruction byte at PC.
- mem_valid  in  1  instr_byte is valid; a fetch transfer occurs when fetch_req && mem_valid. The datapath increments PC on every transfer.
- instr_byte  in  8  fetched opcode or post-prefix byte.
- uop_addr  out  9  microcode index: {cb_prefix, opcode}.
- uop_step  out  3  micro-step within the current instruction.
- uop_valid  out  1  uop_addr/uop_step are executing this cycle.
- uop_stall  in  1  datapath wait; holds the current step.
- uop_last  in  1  control-word bit: this step ends the instruction.
- uop_halt  in  1  control-word bit: enter HALT after this step.
- irq_pending  in  1  an enabled interrupt is flagged (IE & IF ≠ 0).
- ime  in  1  interrupt master enable.
- irq_ack  out  1  one-cycle pulse on interrupt-entry dispatch.
- illegal_op  out  1  sticky illegal-opcode flag; present only with the trap feature and tied to 0 otherwise.

## Operation
- States are FETCH, CB_FETCH, EXEC, IRQ, HALT, and LOCK. LOCK exists only with the trap feature.
- FETCH:
  - fetch_req=1 and uop_valid=0.
  - On transfer with byte 0xCB, go to CB_FETCH.
  - On transfer with any other byte, latch uop_addr={1'b0,byte}, set step=0, and go to EXEC.
- CB_FETCH: fetch_req=1. On transfer, latch uop_addr={1'b1,byte}, set step=0, and go to EXEC. The prefix never reaches the ROM.
- EXEC: uop_valid=1.
  - If uop_stall, hold everything.
  - Otherwise, an "end" occurs when uop_last || step==MAX_STEP.
  - Without an end, step increments by 1.
  - At an end, priority is: uop_halt → HALT; else irq_pending&&ime → IRQ; else → FETCH.
  - uop_halt without an end is ignored.
- IRQ:
  - On entry: uop_addr=IRQ_OPCODE, step=0, irq_ack=1 for the entry cycle only.
  - Then proceed as EXEC, including steps, stalls, and end handling.
  - A nested irq_pending at the end of the IRQ sequence is honoured only if ime is still 1.
- HALT: fetch_req=0 and uop_valid=0. When irq_pending, go to IRQ if ime, else to FETCH (exit without service).
- Boundary conditions:
  - mem_valid without fetch_req is ignored.
  - irq_pending is sampled only at ends and in HALT, never mid-instruction.
  - uop_stall has priority over the end condition.
  - rst_n low in any state returns to FETCH on the next edge, discarding any partial fetch or step.

## Timing
- Reset values: fetch_req=0, uop_valid=0, uop_addr=0, uop_step=0, irq_ack=0, illegal_op=0. The state is FETCH, so fetch_req=1 on the first cycle after rst_n rises.
- Registered outputs. A transfer at edge N gives uop_valid=1 with the new uop_addr in cycle N+1.
- With no stalls, an instruction with k steps and a zero-wait fetch occupies 1+k cycles; a CB instruction occupies 2+k.
- After an end at edge N, the state is FETCH, IRQ or HALT in cycle N+1.
- HALT exit takes 1 cycle after irq_pending is seen.

## Configuration
- UCODE_SEQ_ILLEGAL_TRAP_EN defined:
  - In FETCH, a transfer of an unprefixed byte in {D3,DB,DD,E3,E4,EB,EC,ED,F4,FC,FD} enters LOCK and sets illegal_op.
  - LOCK holds fetch_req=0 and uop_valid=0 and ignores interrupts until reset.
  - IRQ_OPCODE injection never traps.
- Undefined: illegal bytes execute their microcode entry like any opcode; illegal_op is constant 0 and there is no LOCK state.

## Test plan
- Reset, then mem_valid=1 with byte 0x00 and uop_last=1 on step 0: uop_addr=0x000 and step=0 for 1 cycle, then fetch_req=1 again. The loop repeats every 2 cycles.
- Byte 0xCB then 0x37, uop_last on step 1: uop_addr=0x137 with steps 0,1. fetch_req is high for 2 transfers and the prefix is never seen on uop_addr.
- 3-step op with uop_stall high for 2 cycles at step 1: step sequence 0,1,1,1,2, then FETCH.
- irq_pending=1, ime=1 raised mid-instruction: the instruction completes, then uop_addr=0x0FD with irq_ack high exactly 1 cycle. With ime=0, FETCH follows instead.
- Opcode 0x76 with uop_halt&&uop_last: fetch_req=0 and uop_valid=0 until irq_pending. With ime=0 the next state is FETCH (no ack); with ime=1 it is IRQ.
- Trap enabled, byte 0xD3 fetched: illegal_op=1, outputs idle and stay so under irq_pending until rst_n low. Trap disabled: uop_addr=0x0D3.
